// File: rtl/key_debounce_lbus.sv
// key_debounce_lbus
//   Debounces NUM raw key pins and presents the stable levels, latched
//   press/release events, an interrupt enable mask and a level interrupt
//   on a byte-wide local bus slave.
//
//   Ports
//     lb_clk   in   sole clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     xt_lb    in   local bus slave request (lb_slave_t)
//     rdata    out  combinational read data, 0 when nothing is addressed
//     key_in   in   raw asynchronous key pins [NUM-1:0]
//     irq      out  registered level interrupt
//
//   Register map
//     8'd23  R    stable key levels (1 = pressed)
//     8'd24  W1C  press events
//     8'd25  W1C  release events
//     8'd26  RW   interrupt enable

package key_debounce_lbus_pkg;

    typedef struct packed {
        logic       we;
        logic       re;
        logic [7:0] addr;
        logic [7:0] wdata;
    } lb_slave_t;

    function automatic logic MatchWLB(input lb_slave_t lb, input logic [7:0] a);
        return lb.we && (lb.addr == a);
    endfunction

    function automatic logic MatchRLB(input lb_slave_t lb, input logic [7:0] a);
        return lb.re && (lb.addr == a);
    endfunction

endpackage

module key_debounce_lbus
    import key_debounce_lbus_pkg::*;
#(
    parameter int NUM             = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic            lb_clk,
    input  logic            rst_n,
    input  lb_slave_t       xt_lb,
    output logic [7:0]      rdata,
    input  logic [NUM-1:0]  key_in,
    output logic            irq
);

    localparam logic [7:0] ADDR_STABLE  = 8'd23;
    localparam logic [7:0] ADDR_PRESS   = 8'd24;
    localparam logic [7:0] ADDR_RELEASE = 8'd25;
    localparam logic [7:0] ADDR_IRQ_EN  = 8'd26;

    localparam int          CW       = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM-1:0] key_norm;
    logic [NUM-1:0] sync1_q, sync2_q;
    logic [CW-1:0]  cnt_q [NUM];
    logic [CW-1:0]  cnt_d [NUM];
    logic [NUM-1:0] stable_q, stable_d;
    logic [NUM-1:0] stable_dly_q;
    logic [NUM-1:0] press_q, press_d;
    logic [NUM-1:0] release_q, release_d;
    logic [NUM-1:0] irq_en_q, irq_en_d;
    logic           irq_q, irq_d;
    logic [NUM-1:0] press_clr, release_clr;

    // Polarity is normalised ahead of the synchroniser so that the cleared
    // synchroniser reads as "released": a key held through reset is then seen
    // as a fresh press after the full synchroniser + debounce latency.
    assign key_norm = (ACTIVE_LOW != 0) ? ~key_in : key_in;

    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            cnt_d[i]    = cnt_q[i];
            stable_d[i] = stable_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]    = '0;
                stable_d[i] = ~stable_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        press_clr   = MatchWLB(xt_lb, ADDR_PRESS)   ? xt_lb.wdata[NUM-1:0] : '0;
        release_clr = MatchWLB(xt_lb, ADDR_RELEASE) ? xt_lb.wdata[NUM-1:0] : '0;
        // A newly detected edge wins over a same-cycle W1C.
        press_d     = (press_q   & ~press_clr)   | (stable_q & ~stable_dly_q);
        release_d   = (release_q & ~release_clr) | (~stable_q & stable_dly_q);
        irq_en_d    = MatchWLB(xt_lb, ADDR_IRQ_EN) ? xt_lb.wdata[NUM-1:0] : irq_en_q;
        irq_d       = |((press_q | release_q) & irq_en_q);
    end

    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            press_q      <= '0;
            release_q    <= '0;
            irq_en_q     <= '0;
            irq_q        <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= key_norm;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= press_d;
            release_q    <= release_d;
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
            for (int i = 0; i < NUM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (MatchRLB(xt_lb, ADDR_STABLE)) begin
            rdata[NUM-1:0] = stable_q;
        end else if (MatchRLB(xt_lb, ADDR_PRESS)) begin
            rdata[NUM-1:0] = press_q;
        end else if (MatchRLB(xt_lb, ADDR_RELEASE)) begin
            rdata[NUM-1:0] = release_q;
        end else if (MatchRLB(xt_lb, ADDR_IRQ_EN)) begin
            rdata[NUM-1:0] = irq_en_q;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_key_debounce_lbus.sv
module tb_key_debounce_lbus;
    import key_debounce_lbus_pkg::*;

    localparam int NUM = 4;
    localparam int DC  = 4;

    logic            lb_clk = 1'b0;
    logic            rst_n;
    lb_slave_t       xt_lb;
    logic [7:0]      rdata;
    logic [NUM-1:0]  key_in;
    logic            irq;

    always #5 lb_clk = ~lb_clk;

    key_debounce_lbus #(.NUM(NUM), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DC)) dut (
        .lb_clk (lb_clk),
        .rst_n  (rst_n),
        .xt_lb  (xt_lb),
        .rdata  (rdata),
        .key_in (key_in),
        .irq    (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pressed-level history per clock edge since reset,
    // accepted levels, events, enable and interrupt.
    logic [3:0] hist[$];
    int         e;
    logic [3:0] m_stable, m_stable_prev, m_press, m_rel, m_en;
    logic       m_irq;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(4'b0);
        e = 0;
        m_stable = '0; m_stable_prev = '0; m_press = '0; m_rel = '0; m_en = '0; m_irq = 1'b0;
    endtask

    // Pressed level the debouncer evaluates at edge j: the pin value sampled
    // two edges earlier; before that the synchroniser reads "released".
    function automatic logic [3:0] lvl_used(input int j);
        if (j - 2 >= 1) return hist[j-2];
        return 4'b0;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'd23:   return {4'b0, m_stable};
            8'd24:   return {4'b0, m_press};
            8'd25:   return {4'b0, m_rel};
            8'd26:   return {4'b0, m_en};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step(input logic [3:0] keys, input logic we, input logic [7:0] a,
                              input logic [7:0] wd);
        logic [3:0] nstab, lv, clr_p, clr_r;
        logic       nirq, all_diff;
        e++;
        hist.push_back(~keys);
        nirq  = |((m_press | m_rel) & m_en);
        clr_p = (we && a == 8'd24) ? wd[3:0] : 4'b0;
        clr_r = (we && a == 8'd25) ? wd[3:0] : 4'b0;
        m_press = (m_press & ~clr_p) | (m_stable & ~m_stable_prev);
        m_rel   = (m_rel & ~clr_r) | (~m_stable & m_stable_prev);
        if (we && a == 8'd26) m_en = wd[3:0];
        // A level is accepted once it has disagreed with the stable value
        // for DC consecutive evaluations.
        nstab = m_stable;
        for (int i = 0; i < NUM; i++) begin
            all_diff = 1'b1;
            for (int j = e - DC + 1; j <= e; j++) begin
                lv = lvl_used(j);
                if (lv[i] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) nstab[i] = ~m_stable[i];
        end
        m_stable_prev = m_stable;
        m_stable      = nstab;
        m_irq         = nirq;
    endtask

    // One bus cycle: drive, check outputs against the model (and optionally
    // against explicit expectations), then take the clock edge.
    task automatic cyc(input logic [3:0] keys, input logic we, input logic re,
                       input logic [7:0] a, input logic [7:0] wd,
                       input logic chk, input logic [7:0] erd, input logic eirq,
                       input string tag);
        key_in      = keys;
        xt_lb.we    = we;
        xt_lb.re    = re;
        xt_lb.addr  = a;
        xt_lb.wdata = wd;
        #1;
        if (re) check8({tag, " rdata/model"}, rdata, m_read(a));
        check1({tag, " irq/model"}, irq, m_irq);
        if (chk) begin
            if (re) check8({tag, " rdata"}, rdata, erd);
            check1({tag, " irq"}, irq, eirq);
        end
        @(posedge lb_clk);
        model_step(keys, we, a, wd);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        xt_lb = '0;
        model_reset();
        repeat (2) @(posedge lb_clk);
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] keys;
        logic       we;
        logic       re;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_irq;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [3:0] keys;
        int r;
        key_in = 4'hF;
        xt_lb  = '0;

        // Clean press of key 0, readback, irq enable and W1C.
        for (int i = 0; i < 6; i++) tbl[i] = '{4'hE, 1'b0, 1'b1, 8'd23, 8'h00, 8'h00, 1'b0};
        tbl[6]  = '{4'hE, 1'b0, 1'b1, 8'd23, 8'h00, 8'h01, 1'b0};
        tbl[7]  = '{4'hE, 1'b0, 1'b1, 8'd24, 8'h00, 8'h01, 1'b0};
        tbl[8]  = '{4'hE, 1'b0, 1'b1, 8'd24, 8'h00, 8'h01, 1'b0};
        tbl[9]  = '{4'hE, 1'b0, 1'b1, 8'd25, 8'h00, 8'h00, 1'b0};
        tbl[10] = '{4'hE, 1'b0, 1'b1, 8'd27, 8'h00, 8'h00, 1'b0};
        tbl[11] = '{4'hE, 1'b1, 1'b0, 8'd26, 8'hF1, 8'h00, 1'b0};
        tbl[12] = '{4'hE, 1'b0, 1'b1, 8'd26, 8'h00, 8'h01, 1'b0};
        tbl[13] = '{4'hE, 1'b0, 1'b1, 8'd26, 8'h00, 8'h01, 1'b1};
        tbl[14] = '{4'hE, 1'b1, 1'b0, 8'd24, 8'h01, 8'h00, 1'b1};
        tbl[15] = '{4'hE, 1'b0, 1'b1, 8'd24, 8'h00, 8'h00, 1'b1};
        tbl[16] = '{4'hE, 1'b0, 1'b1, 8'd23, 8'h00, 8'h01, 1'b0};

        do_reset();
        for (int i = 0; i < 17; i++)
            cyc(tbl[i].keys, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata,
                1'b1, tbl[i].exp_rd, tbl[i].exp_irq, $sformatf("tbl[%0d]", i));

        // Glitch on key 1 shorter than the debounce window.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(4'hD, 1'b0, 1'b1, 8'd23, 8'h00, 1'b1, 8'h00, 1'b0, "glitch lo");
        for (int i = 0; i < 12; i++)
            cyc(4'hF, 1'b0, 1'b1, 8'(23 + (i % 3)), 8'h00, 1'b1, 8'h00, 1'b0, "glitch hi");

        // Same-cycle set and W1C of press events.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(4'hE, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 8'h00, 1'b0, "w1c pre");
        for (int i = 9; i < 15; i++) cyc(4'hA, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 8'h00, 1'b0, "w1c wait");
        cyc(4'hA, 1'b0, 1'b1, 8'd24, 8'h00, 1'b1, 8'h01, 1'b0, "w1c before");
        cyc(4'hA, 1'b1, 1'b0, 8'd24, 8'h01, 1'b0, 8'h00, 1'b0, "w1c write");
        cyc(4'hA, 1'b0, 1'b1, 8'd24, 8'h00, 1'b1, 8'h04, 1'b0, "w1c after");

        // Release interrupt on key 1.
        do_reset();
        cyc(4'hD, 1'b1, 1'b0, 8'd26, 8'h02, 1'b0, 8'h00, 1'b0, "irq en");
        for (int i = 1; i < 10; i++) cyc(4'hD, 1'b0, 1'b1, 8'd24, 8'h00, 1'b0, 8'h00, 1'b0, "irq press");
        cyc(4'hD, 1'b1, 1'b0, 8'd24, 8'h02, 1'b1, 8'h00, 1'b1, "irq clr press");
        cyc(4'hD, 1'b0, 1'b1, 8'd24, 8'h00, 1'b1, 8'h00, 1'b1, "irq clr lag");
        cyc(4'hD, 1'b0, 1'b1, 8'd24, 8'h00, 1'b1, 8'h00, 1'b0, "irq cleared");
        for (int i = 13; i < 20; i++) cyc(4'hF, 1'b0, 1'b1, 8'd25, 8'h00, 1'b1, 8'h00, 1'b0, "irq rel wait");
        cyc(4'hF, 1'b0, 1'b1, 8'd25, 8'h00, 1'b1, 8'h02, 1'b0, "irq rel evt");
        cyc(4'hF, 1'b0, 1'b1, 8'd25, 8'h00, 1'b1, 8'h02, 1'b1, "irq rel set");
        cyc(4'hF, 1'b1, 1'b0, 8'd25, 8'h02, 1'b1, 8'h00, 1'b1, "irq rel w1c");
        cyc(4'hF, 1'b0, 1'b1, 8'd25, 8'h00, 1'b1, 8'h00, 1'b1, "irq rel lag");
        cyc(4'hF, 1'b0, 1'b1, 8'd25, 8'h00, 1'b1, 8'h00, 1'b0, "irq rel off");

        // Reset in the middle of key 3's count, key held through release.
        do_reset();
        cyc(4'hF, 1'b1, 1'b0, 8'd26, 8'h0F, 1'b0, 8'h00, 1'b0, "mid en");
        for (int i = 0; i < 4; i++) cyc(4'h7, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 8'h00, 1'b0, "mid count");
        rst_n = 1'b0;
        model_reset();
        for (int a = 23; a <= 26; a++) begin
            xt_lb.re = 1'b1; xt_lb.we = 1'b0; xt_lb.addr = 8'(a);
            #1;
            check8("reset rdata", rdata, 8'h00);
            check1("reset irq", irq, 1'b0);
        end
        repeat (2) @(posedge lb_clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 7; i++) cyc(4'h7, 1'b0, 1'b1, 8'd24, 8'h00, 1'b1, 8'h00, 1'b0, "mid wait");
        cyc(4'h7, 1'b0, 1'b1, 8'd24, 8'h00, 1'b1, 8'h08, 1'b0, "mid press");

        // Randomised keys and bus traffic against the model.
        do_reset();
        keys = 4'hF;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) keys[$urandom_range(0, 3)] ^= 1'b1;
            r = $urandom_range(0, 9);
            if (r <= 4)
                cyc(keys, 1'b0, 1'b1, 8'($urandom_range(22, 28)), 8'h00, 1'b0, 8'h00, 1'b0, "rand rd");
            else if (r <= 6)
                cyc(keys, 1'b1, 1'b0, 8'($urandom_range(24, 25)), 8'($urandom), 1'b0, 8'h00, 1'b0, "rand w1c");
            else if (r == 7)
                cyc(keys, 1'b1, 1'b0, 8'd26, 8'($urandom), 1'b0, 8'h00, 1'b0, "rand en");
            else if (r == 8)
                cyc(keys, 1'b1, 1'b0, 8'd23, 8'($urandom), 1'b0, 8'h00, 1'b0, "rand ro");
            else
                cyc(keys, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 8'h00, 1'b0, "rand idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
